// File: rtl/audio_sample_pacer.sv
// Paced FIFO drain: one pop per programmable tick, with a substitute sample and an underrun count when the FIFO is empty.
// Build option AUDIO_SAMPLE_PACER_HOLD_EN: on underrun, hold the last delivered sample instead of emitting zero.
module audio_sample_pacer #(
    parameter int DATA_SIZE = 28,
    parameter int DIV_WIDTH = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic                 fifo_empty,
    output logic                 bus_chipselect,
    output logic                 bus_read,
    output logic                 bus_address,
    input  logic [31:0]          bus_read_data,
    output logic [DATA_SIZE-1:0] sample_data,
    output logic                 sample_valid,
    output logic [CNT_WIDTH-1:0] underrun_count,
    input  logic                 clear_underrun,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_REQ  = 2'd2;
    localparam logic [1:0] S_CAP  = 2'd3;

    localparam logic [DIV_WIDTH-1:0] MIN_DIV = DIV_WIDTH'(3);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [1:0]           r_state;
    logic [DIV_WIDTH-1:0] r_pcnt;
    logic [DATA_SIZE-1:0] r_sample_data;
    logic                 r_sample_valid;
    logic [CNT_WIDTH-1:0] r_underrun_count;

    logic [DIV_WIDTH-1:0] w_eff_div;
    logic                 w_tick;
    logic                 w_underrun;
    logic                 w_unused_bus_bits;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) return v;
        return v + CNT_ONE;
    endfunction

    assign w_eff_div  = (divisor < MIN_DIV) ? MIN_DIV : divisor;
    assign w_tick     = enable && (r_pcnt == '0);
    assign w_underrun = (r_state == S_WAIT) && w_tick && fifo_empty;

    // Only the sample bits of the bus word are consumed.
    assign w_unused_bus_bits = ^bus_read_data[31:DATA_SIZE];

    always_ff @(posedge clk) begin
        if (rst || !enable || w_tick) begin
            r_pcnt <= w_eff_div;
        end else begin
            r_pcnt <= r_pcnt - DIV_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_sample_data    <= '0;
            r_sample_valid   <= 1'b0;
            r_underrun_count <= '0;
        end else begin
            r_sample_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                    end else if (w_tick) begin
                        if (!fifo_empty) begin
                            r_state <= S_REQ;
                        end else begin
                            r_sample_valid <= 1'b1;
`ifdef AUDIO_SAMPLE_PACER_HOLD_EN
                            r_sample_data  <= r_sample_data;
`else
                            r_sample_data  <= '0;
`endif
                        end
                    end
                end
                S_REQ: begin
                    r_state <= S_CAP;
                end
                S_CAP: begin
                    // Bridge data is registered, so it is valid here, one cycle after the strobe.
                    r_sample_data  <= bus_read_data[DATA_SIZE-1:0];
                    r_sample_valid <= 1'b1;
                    r_state        <= enable ? S_WAIT : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            if (clear_underrun) begin
                r_underrun_count <= '0;
            end else if (w_underrun) begin
                r_underrun_count <= sat_inc(r_underrun_count);
            end
        end
    end

    assign bus_chipselect = (r_state == S_REQ);
    assign bus_read       = (r_state == S_REQ);
    assign bus_address    = 1'b0;
    assign busy           = (r_state == S_REQ) || (r_state == S_CAP);
    assign sample_data    = r_sample_data;
    assign sample_valid   = r_sample_valid;
    assign underrun_count = r_underrun_count;

endmodule

// File: tb/tb_audio_sample_pacer.sv
// Bench for audio_sample_pacer: directed phases plus a random phase, checked cycle by cycle against a tick-schedule model.
module tb_audio_sample_pacer;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int MAXC = 2048;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] divisor;
    logic        fifo_empty;
    logic        bus_chipselect;
    logic        bus_read;
    logic        bus_address;
    logic [31:0] bus_read_data;
    logic [27:0] sample_data;
    logic        sample_valid;
    logic [CW-1:0] underrun_count;
    logic        clear_underrun;
    logic        busy;

    audio_sample_pacer #(.DATA_SIZE(28), .DIV_WIDTH(16), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .divisor(divisor),
        .fifo_empty(fifo_empty), .bus_chipselect(bus_chipselect), .bus_read(bus_read),
        .bus_address(bus_address), .bus_read_data(bus_read_data),
        .sample_data(sample_data), .sample_valid(sample_valid),
        .underrun_count(underrun_count), .clear_underrun(clear_underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit rnd_bus = 0;

    // Expected-event schedule, indexed by absolute cycle number.
    bit          e_strobe [MAXC];
    bit          e_valid  [MAXC];
    bit          e_busy   [MAXC];
    bit          e_cap    [MAXC];
    bit          e_dupd   [MAXC];
    logic [27:0] e_dval   [MAXC];

    bit          model_ok = 0;
    bit          prev_en = 0;
    int          seg_start = 0;
    int          cur_d = 3;
    int          pend_d = 3;
    int          cnt_vis = 0;
    logic [27:0] data_vis = '0;

    function automatic int eff_div(input logic [15:0] d);
        return (d < 16'd3) ? 3 : int'(d);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h cycle=%0d", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic check_cycle(input int c);
        if (!model_ok) return;
        if (e_dupd[c]) data_vis = e_dval[c];
        chk("chipselect", {31'd0, bus_chipselect}, {31'd0, e_strobe[c]});
        chk("bus_read", {31'd0, bus_read}, {31'd0, e_strobe[c]});
        chk("bus_address", {31'd0, bus_address}, 32'd0);
        chk("sample_valid", {31'd0, sample_valid}, {31'd0, e_valid[c]});
        chk("busy", {31'd0, busy}, {31'd0, e_busy[c]});
        chk("sample_data", {4'd0, sample_data}, {4'd0, data_vis});
        chk("underrun_count", {28'd0, underrun_count}, 32'(cnt_vis));
    endtask

    task automatic model_step(input int c);
        bit tick;
        int off;
        int nxt;
        if (rst) begin
            for (int i = c + 1; i < MAXC; i++) begin
                e_strobe[i] = 0; e_valid[i] = 0; e_busy[i] = 0;
                e_cap[i] = 0; e_dupd[i] = 0;
            end
            e_dupd[c+1] = 1; e_dval[c+1] = '0;
            cnt_vis = 0; prev_en = 0; pend_d = eff_div(divisor); model_ok = 1;
            return;
        end
        if (!model_ok) return;
        if (e_cap[c]) begin
            e_dupd[c+1] = 1; e_dval[c+1] = bus_read_data[27:0];
        end
        tick = 0;
        if (!enable) begin
            pend_d = eff_div(divisor);
        end else begin
            if (!prev_en) begin
                seg_start = c; cur_d = pend_d;
            end
            off = c - seg_start;
            if (off >= cur_d && ((off - cur_d) % (cur_d + 1)) == 0) tick = 1;
        end
        prev_en = enable;
        nxt = cnt_vis;
        if (tick && !fifo_empty) begin
            e_strobe[c+1] = 1; e_busy[c+1] = 1; e_busy[c+2] = 1;
            e_cap[c+2] = 1; e_valid[c+3] = 1;
        end
        if (tick && fifo_empty) begin
            e_valid[c+1] = 1;
            nxt = (cnt_vis + 1 > CMAX) ? CMAX : cnt_vis + 1;
`ifndef AUDIO_SAMPLE_PACER_HOLD_EN
            e_dupd[c+1] = 1; e_dval[c+1] = '0;
`endif
        end
        if (clear_underrun) nxt = 0;
        cnt_vis = nxt;
    endtask

    task automatic run_cycle();
        if (cyc + 4 >= MAXC) begin
            $display("FAIL cycle_budget: observed=%0d expected<%0d", cyc, MAXC - 4);
            $fatal(1, "cycle budget exhausted");
        end
        if (rnd_bus) bus_read_data = $urandom;
        @(negedge clk);
        check_cycle(cyc);
        model_step(cyc);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst = 1; enable = 0; divisor = 16'd9; fifo_empty = 1'b1;
        bus_read_data = '0; clear_underrun = 0;
        @(posedge clk);
        #1;

        // Reset state
        repeat (2) run_cycle();
        rst = 0;
        run_cycle();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, sample_valid}, 32'd0);
        chk("rst_data", {4'd0, sample_data}, 32'd0);
        chk("rst_count", {28'd0, underrun_count}, 32'd0);

        // Basic pop, divisor 9
        divisor = 16'd9; fifo_empty = 1'b0; bus_read_data = {4'h5, 28'h0ABCDEF};
        run_cycle();
        enable = 1;
        repeat (10) run_cycle();
        chk("basic_strobe", {31'd0, bus_read}, 32'd1);
        run_cycle();
        chk("basic_strobe_len", {31'd0, bus_read}, 32'd0);
        run_cycle();
        chk("basic_valid", {31'd0, sample_valid}, 32'd1);
        chk("basic_data", {4'd0, sample_data}, 32'h0ABCDEF);
        rnd_bus = 1;
        repeat (22) run_cycle();

        // Underrun: exactly three ticks in 30 cycles
        fifo_empty = 1'b1;
        repeat (30) run_cycle();
        chk("underrun_3", {28'd0, underrun_count}, 32'd3);

        // Minimum divisor clamp
        enable = 0; divisor = 16'd0; fifo_empty = 1'b0;
        repeat (4) run_cycle();
        enable = 1;
        repeat (40) run_cycle();

        // Disable in the REQ cycle
        enable = 0; divisor = 16'd5;
        repeat (4) run_cycle();
        enable = 1;
        repeat (6) run_cycle();
        chk("dis_req_strobe", {31'd0, bus_read}, 32'd1);
        enable = 0;
        repeat (2) run_cycle();
        chk("dis_valid", {31'd0, sample_valid}, 32'd1);
        repeat (10) run_cycle();
        chk("dis_idle_busy", {31'd0, busy}, 32'd0);

        // Saturation at 15, then clear coinciding with an underrun tick
        clear_underrun = 1; divisor = 16'd3; fifo_empty = 1'b1;
        run_cycle();
        clear_underrun = 0;
        repeat (2) run_cycle();
        enable = 1;
        repeat (69) run_cycle();
        chk("sat_count", {28'd0, underrun_count}, 32'd15);
        repeat (2) run_cycle();
        clear_underrun = 1;
        run_cycle();
        clear_underrun = 0;
        chk("clr_priority", {28'd0, underrun_count}, 32'd0);
        chk("clr_tick_valid", {31'd0, sample_valid}, 32'd1);

        // Reset in the CAP cycle
        enable = 0; fifo_empty = 1'b0;
        repeat (3) run_cycle();
        enable = 1;
        repeat (5) run_cycle();
        chk("cap_busy", {31'd0, busy}, 32'd1);
        rst = 1;
        run_cycle();
        rst = 0;
        chk("rstcap_busy", {31'd0, busy}, 32'd0);
        chk("rstcap_valid", {31'd0, sample_valid}, 32'd0);
        chk("rstcap_data", {4'd0, sample_data}, 32'd0);
        chk("rstcap_read", {31'd0, bus_read}, 32'd0);
        repeat (4) run_cycle();

        // Random traffic: empty flag, enable, clear and bus data all vary
        for (int i = 0; i < 400; i++) begin
            fifo_empty     = ($urandom_range(0, 2) == 0);
            clear_underrun = ($urandom_range(0, 15) == 0);
            enable         = ($urandom_range(0, 11) != 0);
            if (!enable) divisor = 16'($urandom_range(0, 8));
            run_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
